// File: rtl/ecc_pe_array_ctrl.sv
// Sequencer for the Montgomery systolic PE chain: clears the chain, feeds operand-A
// words with the per-iteration quotient m, then drains result words to the result RAM.
//
// state | meaning
// IDLE  | waiting for start_i
// CLR   | one-cycle chain clear pulse
// FEED  | stream A words (odd cyc) and compute m (even cyc), 2*S_NUM cycles
// DRAIN | collect result words (odd cyc), m still updated, 2*S_NUM cycles
// DONE  | one-cycle completion pulse
module ecc_pe_array_ctrl #(
  parameter int RADIX  = 32,
  parameter int S_NUM  = 12,
  parameter int ADDR_W = $clog2(S_NUM),
  parameter int CNT_W  = $clog2(2*S_NUM+1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              zeroize_i,
  input  logic [RADIX-1:0]  n_prime_i,
  input  logic [RADIX-1:0]  s0_i,
  input  logic [RADIX-1:0]  a_rd_data_i,
  output logic              a_rd_en_o,
  output logic [ADDR_W-1:0] a_rd_addr_o,
  output logic              pe_start_o,
  output logic              pe_odd_o,
  output logic [RADIX-1:0]  a_word_o,
  output logic [RADIX-1:0]  m_word_o,
  output logic              res_we_o,
  output logic [ADDR_W-1:0] res_addr_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(2*S_NUM-1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [RADIX-1:0]   m_word_q, m_word_d;
  logic               in_feed, in_drain, odd_cyc;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    m_word_d = m_word_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_CLR;
      ST_CLR: begin
        cyc_d   = '0;
        state_d = ST_FEED;
      end
      ST_FEED, ST_DRAIN: begin
        // Quotient is taken from the head PE output on even cycles only.
        if (!cyc_q[0]) m_word_d = s0_i * n_prime_i;
        if (cyc_q == CYC_LAST) begin
          cyc_d   = '0;
          state_d = (state_q == ST_FEED) ? ST_DRAIN : ST_DONE;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (zeroize_i) begin
      state_d  = ST_IDLE;
      cyc_d    = '0;
      m_word_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      m_word_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      m_word_q <= m_word_d;
    end
  end

  assign in_feed  = (state_q == ST_FEED);
  assign in_drain = (state_q == ST_DRAIN);
  assign odd_cyc  = cyc_q[0];

  // RAM read issued on even cycle returns on the following odd cycle.
  assign a_rd_en_o   = in_feed & ~odd_cyc;
  assign a_rd_addr_o = a_rd_en_o ? ADDR_W'(cyc_q >> 1) : '0;
  assign a_word_o    = (in_feed & odd_cyc) ? a_rd_data_i : '0;
  assign res_we_o    = in_drain & odd_cyc;
  assign res_addr_o  = res_we_o ? ADDR_W'(cyc_q >> 1) : '0;
  assign pe_odd_o    = (in_feed | in_drain) & odd_cyc;
  assign pe_start_o  = (state_q == ST_CLR);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign m_word_o    = m_word_q;

endmodule

// File: tb/tb_ecc_pe_array_ctrl.sv
// Scoreboard bench for ecc_pe_array_ctrl: driver pushes a per-cycle expected trace
// for each operation, a negedge monitor pops one entry per busy cycle.
module tb_ecc_pe_array_ctrl;
  localparam int RADIX  = 32;
  localparam int S_NUM  = 12;
  localparam int ADDR_W = 4;
  localparam int OP_LEN = 4*S_NUM+2;

  typedef struct packed {
    logic              pe_start;
    logic              pe_odd;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              we;
    logic [ADDR_W-1:0] res_addr;
    logic              busy;
    logic              done;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [RADIX-1:0]  a_word;
    logic [RADIX-1:0]  m_word;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n, start_i, zeroize_i;
  logic [RADIX-1:0]  n_prime_i, s0_i, a_rd_data_i;
  logic              a_rd_en_o, pe_start_o, pe_odd_o, res_we_o, busy_o, done_o;
  logic [ADDR_W-1:0] a_rd_addr_o, res_addr_o;
  logic [RADIX-1:0]  a_word_o, m_word_o;

  logic [RADIX-1:0]  mem [0:S_NUM-1];
  exp_t              sb [$];
  logic [RADIX-1:0]  m_cur = '0;
  logic [RADIX-1:0]  m_idle_exp = '0;
  bit                running = 1'b0;
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  ecc_pe_array_ctrl #(.RADIX(RADIX), .S_NUM(S_NUM)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .zeroize_i(zeroize_i),
    .n_prime_i(n_prime_i), .s0_i(s0_i), .a_rd_data_i(a_rd_data_i),
    .a_rd_en_o(a_rd_en_o), .a_rd_addr_o(a_rd_addr_o), .pe_start_o(pe_start_o),
    .pe_odd_o(pe_odd_o), .a_word_o(a_word_o), .m_word_o(m_word_o),
    .res_we_o(res_we_o), .res_addr_o(res_addr_o), .busy_o(busy_o), .done_o(done_o)
  );

  // Operand RAM with one-cycle read latency.
  always @(posedge clk) if (a_rd_en_o) a_rd_data_i <= mem[a_rd_addr_o];

  always @(negedge clk) begin
    exp_t e;
    ctrl_t act;
    if (running) begin
      act = '{pe_start: pe_start_o, pe_odd: pe_odd_o, rd_en: a_rd_en_o, rd_addr: a_rd_addr_o,
              we: res_we_o, res_addr: res_addr_o, busy: busy_o, done: done_o};
      if (busy_o) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow: busy with no expected entry at %0t", $time);
        end else begin
          e = sb.pop_front();
          if (act !== e.ctrl) begin
            failures++;
            $display("FAIL ctrl: actual=%h required=%h at %0t", act, e.ctrl, $time);
          end
          checks++;
          if (a_word_o !== e.a_word) begin
            failures++;
            $display("FAIL a_word: actual=%h required=%h at %0t", a_word_o, e.a_word, $time);
          end
          checks++;
          if (m_word_o !== e.m_word) begin
            failures++;
            $display("FAIL m_word: actual=%h required=%h at %0t", m_word_o, e.m_word, $time);
          end
        end
      end else begin
        checks++;
        if (act !== '0 || a_word_o !== '0 || m_word_o !== m_idle_exp) begin
          failures++;
          $display("FAIL idle_out: ctrl=%h a=%h m=%h required ctrl=0 a=0 m=%h at %0t",
                   act, a_word_o, m_word_o, m_idle_exp, $time);
        end
      end
    end
  end

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      s0_i    = $urandom();
    end
  endtask

  // One operation; abort_t>0 aborts (zeroize or reset) during cycle abort_t.
  task automatic run_op(input bit hold, input int abort_t, input bit abort_rst, input bit directed);
    logic [RADIX-1:0] np;
    logic [RADIX-1:0] s0s [0:OP_LEN];
    logic [RADIX-1:0] m;
    exp_t             e;
    int               c;
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_empty: leftover=%0d required=0", sb.size());
      sb.delete();
    end
    np = directed ? 32'h0000_0003 : $urandom();
    for (int t = 0; t <= OP_LEN; t++) s0s[t] = directed ? 32'hFFFF_FFFF : $urandom();
    for (int k = 0; k < S_NUM; k++) mem[k] = directed ? RADIX'(k+1) : $urandom();
    m = m_cur;
    for (int t = 1; t <= OP_LEN; t++) begin
      e = '0;
      e.ctrl.busy = 1'b1;
      e.m_word    = m;
      if (t == 1) begin
        e.ctrl.pe_start = 1'b1;
      end else if (t <= 2*S_NUM+1) begin
        c = t - 2;
        e.ctrl.pe_odd = c[0];
        if (c % 2 == 0) begin
          e.ctrl.rd_en   = 1'b1;
          e.ctrl.rd_addr = ADDR_W'(c/2);
          m = s0s[t] * np;
        end else begin
          e.a_word = mem[c/2];
        end
      end else if (t <= 4*S_NUM+1) begin
        c = t - (2*S_NUM+2);
        e.ctrl.pe_odd = c[0];
        if (c % 2 == 0) begin
          m = s0s[t] * np;
        end else begin
          e.ctrl.we       = 1'b1;
          e.ctrl.res_addr = ADDR_W'(c/2);
        end
      end else begin
        e.ctrl.done = 1'b1;
      end
      sb.push_back(e);
    end
    m_cur     = m;
    n_prime_i = np;
    s0_i      = s0s[0];
    start_i   = 1'b1;
    zeroize_i = 1'b0;
    for (int t = 1; t <= OP_LEN; t++) begin
      @(posedge clk); #1;
      if (abort_t > 0 && t == abort_t + 1) begin
        reset_n   = 1'b1;
        zeroize_i = 1'b0;
        start_i   = 1'b0;
        checks++;
        if (sb.size() != OP_LEN - abort_t) begin
          failures++;
          $display("FAIL abort_left: actual=%0d required=%0d", sb.size(), OP_LEN - abort_t);
        end
        sb.delete();
        m_cur      = '0;
        m_idle_exp = '0;
        return;
      end
      if (t == 1) begin
        m_idle_exp = m;
        checks++;
        if (busy_o !== 1'b1 || pe_start_o !== 1'b1) begin
          failures++;
          $display("FAIL start_lat: busy=%b pe_start=%b required 1 1", busy_o, pe_start_o);
        end
      end
      if (t == OP_LEN) begin
        checks++;
        if (done_o !== 1'b1) begin
          failures++;
          $display("FAIL done_lat: done=%b required 1 at cycle %0d", done_o, OP_LEN);
        end
      end
      start_i = hold ? 1'b1 : 1'($urandom_range(0, 1));
      s0_i    = s0s[t];
      if (t == abort_t) begin
        if (abort_rst) reset_n = 1'b0;
        else zeroize_i = 1'b1;
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    start_i     = 1'b0;
    zeroize_i   = 1'b0;
    n_prime_i   = '0;
    s0_i        = '0;
    a_rd_data_i = '0;
    for (int k = 0; k < S_NUM; k++) mem[k] = '0;
    @(posedge clk); #1;
    running = 1'b1;
    gap(2);
    reset_n = 1'b1;
    gap(2);
    run_op(1'b0, 0, 1'b0, 1'b1);
    gap(1);
    run_op(1'b0, 9, 1'b0, 1'b0);
    run_op(1'b0, 0, 1'b0, 1'b0);
    run_op(1'b1, 0, 1'b0, 1'b0);
    run_op(1'b1, 0, 1'b0, 1'b0);
    run_op(1'b0, 0, 1'b0, 1'b0);
    run_op(1'b0, 30, 1'b1, 1'b0);
    gap(2);
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, 0, 1'b0, 1'b0);
      gap($urandom_range(0, 3));
    end
    gap(3);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_final: leftover=%0d required=0", sb.size());
    end
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
